// File: rtl/dut_bus_master.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dut_bus_master
//
// Initiator for the OR-combiner register bus. Takes (a, b) operand pairs from
// an input stream, writes a to address 4 and b to address 5 once the slave's
// FIFO-not-full status (addresses 0 and 1) allows it, polls result-valid at
// address 2, pops the result from address 3 and presents it on an output
// stream. One transaction is in flight at a time.
//
// Parameters
//   TIMEOUT  consecutive POLL_Y cycles before the transaction is abandoned
//            (1 .. 65535)
//   DW       operand / result / bus data width
//
// Ports
//   CLK, RST        clock (rising edge), synchronous active-high reset
//   op_a, op_b      operand pair; op_valid / op_ready handshake
//   res_data        registered result; res_valid / res_ready handshake
//   write_address, write_data, write_en, write_rdy   bus write channel
//   read_address, read_en, read_data, read_rdy       bus read channel
//                   (read_data is combinational from read_address)
//   busy            FSM not in IDLE
//   err             sticky timeout flag, cleared only by RST
//   txn_count       completed transactions, wraps at 16 bits
// -----------------------------------------------------------------------------
module dut_bus_master #(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned DW      = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] op_a,
    input  logic [DW-1:0] op_b,
    input  logic          op_valid,
    output logic          op_ready,
    output logic [DW-1:0] res_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [2:0]    write_address,
    output logic [DW-1:0] write_data,
    output logic          write_en,
    input  logic          write_rdy,
    output logic [2:0]    read_address,
    output logic          read_en,
    input  logic [DW-1:0] read_data,
    input  logic          read_rdy,
    output logic          busy,
    output logic          err,
    output logic [15:0]   txn_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL_A,
        S_WR_A,
        S_POLL_B,
        S_WR_B,
        S_POLL_Y,
        S_RD_Y,
        S_OUT
    } state_t;

    // Bus register map
    localparam logic [2:0] A_STAT_A = 3'd0;
    localparam logic [2:0] A_STAT_B = 3'd1;
    localparam logic [2:0] A_STAT_Y = 3'd2;
    localparam logic [2:0] A_POP_Y  = 3'd3;
    localparam logic [2:0] A_PUSH_A = 3'd4;
    localparam logic [2:0] A_PUSH_B = 3'd5;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [DW-1:0] r_res;
    logic          r_err;
    logic [15:0]   r_txn;
    logic [15:0]   r_to;

    logic          w_capture;
    logic          w_load_res;
    logic          w_to_clr;
    logic          w_to_inc;
    logic          w_set_err;
    logic          w_done;
    logic          w_to_last;

    assign w_to_last = (r_to == TO_LAST);

    // State register and datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_err   <= 1'b0;
            r_txn   <= '0;
            r_to    <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_a <= op_a;
                r_b <= op_b;
            end
            if (w_load_res) begin
                r_res <= read_data;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
            if (w_done) begin
                r_txn <= r_txn + 16'd1;
            end
            if (w_to_clr) begin
                r_to <= '0;
            end else if (w_to_inc) begin
                r_to <= r_to + 16'd1;
            end
        end
    end

    // Next state and bus decode. Addresses and write data depend on state and
    // captured operands only; the strobes are additionally qualified by the
    // slave's ready so each access is exactly one accepted cycle.
    always_comb begin
        w_next        = r_state;
        op_ready      = 1'b0;
        write_address = '0;
        write_data    = '0;
        write_en      = 1'b0;
        read_address  = '0;
        read_en       = 1'b0;
        w_capture     = 1'b0;
        w_load_res    = 1'b0;
        w_to_clr      = 1'b0;
        w_to_inc      = 1'b0;
        w_set_err     = 1'b0;
        w_done        = 1'b0;

        case (r_state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    w_capture = 1'b1;
                    w_next    = S_POLL_A;
                end
            end
            S_POLL_A: begin
                read_address = A_STAT_A;
                if (read_data[0]) begin
                    w_next = S_WR_A;
                end
            end
            S_WR_A: begin
                write_address = A_PUSH_A;
                write_data    = r_a;
                if (write_rdy) begin
                    write_en = 1'b1;
                    w_next   = S_POLL_B;
                end
            end
            S_POLL_B: begin
                read_address = A_STAT_B;
                if (read_data[0]) begin
                    w_next = S_WR_B;
                end
            end
            S_WR_B: begin
                write_address = A_PUSH_B;
                write_data    = r_b;
                if (write_rdy) begin
                    write_en = 1'b1;
                    w_to_clr = 1'b1;
                    w_next   = S_POLL_Y;
                end
            end
            S_POLL_Y: begin
                read_address = A_STAT_Y;
                if (read_data[0]) begin
                    w_next = S_RD_Y;
                end else if (w_to_last) begin
                    // Abandon without popping; a late result stays in the
                    // slave and is returned by the next transaction.
                    w_set_err = 1'b1;
                    w_next    = S_IDLE;
                end else begin
                    w_to_inc = 1'b1;
                end
            end
            S_RD_Y: begin
                read_address = A_POP_Y;
                if (read_rdy) begin
                    read_en    = 1'b1;
                    w_load_res = 1'b1;
                    w_next     = S_OUT;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign res_valid = (r_state == S_OUT);
    assign res_data  = r_res;
    assign busy      = (r_state != S_IDLE);
    assign err       = r_err;
    assign txn_count = r_txn;

endmodule

// File: tb/tb_dut_bus_master.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_dut_bus_master
//
// Directed and randomized transactions against dut_bus_master connected to a
// behavioural OR-combiner slave (operand FIFOs, result FIFO with a settable
// result delay, status holds). Expected results are a|b of each accepted pair;
// bus protocol rules are checked every cycle.
// -----------------------------------------------------------------------------
module tb_dut_bus_master;

    localparam int unsigned DW = 8;
    localparam int unsigned TO = 20;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] op_a, op_b;
    logic          op_valid;
    logic          op_ready;
    logic [DW-1:0] res_data;
    logic          res_valid;
    logic          res_ready;
    logic [2:0]    write_address;
    logic [DW-1:0] write_data;
    logic          write_en;
    logic          write_rdy;
    logic [2:0]    read_address;
    logic          read_en;
    logic [DW-1:0] read_data;
    logic          read_rdy;
    logic          busy;
    logic          err;
    logic [15:0]   txn_count;

    always #5 CLK = ~CLK;

    dut_bus_master #(.TIMEOUT(TO), .DW(DW)) dut (
        .CLK(CLK), .RST(RST),
        .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .write_address(write_address), .write_data(write_data),
        .write_en(write_en), .write_rdy(write_rdy),
        .read_address(read_address), .read_en(read_en),
        .read_data(read_data), .read_rdy(read_rdy),
        .busy(busy), .err(err), .txn_count(txn_count)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural slave ----------------
    logic [7:0]  aq[$], bq[$], yq[$];
    int unsigned yt[$];
    bit          hold_a = 0, hold_b = 0, hold_y = 0;
    int unsigned y_lat = 0;
    int unsigned cyc_no = 0;
    logic        st_a, st_b, st_y;
    logic [7:0]  y_head;

    function automatic void refresh();
        st_a = !hold_a && (aq.size() < 4);
        st_b = !hold_b && (bq.size() < 4);
        if (yq.size() > 0) begin
            st_y   = !hold_y && (cyc_no >= yt[0]);
            y_head = yq[0];
        end else begin
            st_y   = 1'b0;
            y_head = '0;
        end
    endfunction

    always_comb begin
        case (read_address)
            3'd0:    read_data = {7'd0, st_a};
            3'd1:    read_data = {7'd0, st_b};
            3'd2:    read_data = {7'd0, st_y};
            3'd3:    read_data = y_head;
            default: read_data = '0;
        endcase
    end

    // ---------------- per-cycle sampling ----------------
    logic        s_we, s_wrdy, s_re, s_acc, s_rvh, s_rv, s_rr, s_opr, s_busy, s_err, s_rst, s_pa;
    logic [2:0]  s_wa, s_ra;
    logic [7:0]  s_wd, s_rd;
    logic [15:0] s_txn;
    int unsigned s_cyc;
    int unsigned n_wr4, n_wr5, n_rd, n_py;
    logic [7:0]  wd4, wd5;
    logic [15:0] exp_txn;

    // Sample at negedge, then let the slave act just after the next posedge.
    task automatic cyc();
        @(negedge CLK);
        s_we = write_en;  s_wa = write_address; s_wd = write_data; s_wrdy = write_rdy;
        s_re = read_en;   s_ra = read_address;
        s_acc = op_valid && op_ready;
        s_rv = res_valid; s_rr = res_ready; s_rvh = res_valid && res_ready;
        s_rd = res_data;  s_opr = op_ready; s_busy = busy; s_err = err;
        s_txn = txn_count; s_rst = RST; s_cyc = cyc_no;
        s_pa = busy && (read_address == 3'd0) && (write_address == 3'd0) && !res_valid;
        if (write_en) check("we_needs_rdy", write_rdy, 1);
        if (read_en) begin
            check("re_addr", read_address, 3);
            check("re_needs_rdy", read_rdy, 1);
        end
        if (s_we && s_wa == 3'd4) begin n_wr4++; wd4 = s_wd; end
        if (s_we && s_wa == 3'd5) begin n_wr5++; wd5 = s_wd; end
        if (s_re) n_rd++;
        if (s_busy && s_ra == 3'd2) n_py++;
        @(posedge CLK);
        #1;
        cyc_no++;
        if (s_rst) begin
            aq.delete(); bq.delete(); yq.delete(); yt.delete();
        end else begin
            if (s_we && s_wa == 3'd4) aq.push_back(s_wd);
            if (s_we && s_wa == 3'd5) bq.push_back(s_wd);
            if (s_re && s_ra == 3'd3 && yq.size() > 0) begin
                void'(yq.pop_front());
                void'(yt.pop_front());
            end
            while (aq.size() > 0 && bq.size() > 0) begin
                yq.push_back(aq.pop_front() | bq.pop_front());
                yt.push_back(cyc_no + y_lat);
            end
        end
        refresh();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_op_ready"}, op_ready, 1);
        check({pfx, "_res_valid"}, res_valid, 0);
        check({pfx, "_res_data"}, res_data, 0);
        check({pfx, "_write_en"}, write_en, 0);
        check({pfx, "_read_en"}, read_en, 0);
        check({pfx, "_write_address"}, write_address, 0);
        check({pfx, "_read_address"}, read_address, 0);
        check({pfx, "_write_data"}, write_data, 0);
        check({pfx, "_err"}, err, 0);
        check({pfx, "_txn_count"}, txn_count, 0);
        check({pfx, "_busy"}, busy, 0);
    endtask

    // One transaction. ha: POLL_A cycles with status held low; wrb: WR_B cycles
    // with write_rdy low; outst: OUT cycles with res_ready low.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b,
                           input int unsigned ha, input int unsigned wrb,
                           input int unsigned outst, input bit rnd,
                           input bit exp_to, input bit chk_lat);
        int unsigned k, pa_n, wrb_n, out_n, c_acc, c_rv, c_pa_last, c_w4;
        bit got_rv, fin;
        n_wr4 = 0; n_wr5 = 0; n_rd = 0; n_py = 0;
        pa_n = 0; wrb_n = 0; out_n = 0; c_rv = 0; c_pa_last = 0; c_w4 = 0;
        got_rv = 0; fin = 0;
        write_rdy = 1; read_rdy = 1; res_ready = 1; hold_a = 0; hold_b = 0;
        refresh();
        op_a = a; op_b = b; op_valid = 1;
        k = 0;
        do begin cyc(); k++; end while (!s_acc && k < 50);
        check("accept", s_acc, 1);
        c_acc = s_cyc;
        op_valid = 0;
        op_a = 8'($urandom); op_b = 8'($urandom);
        k = 0;
        while (!fin && k < 400) begin
            write_rdy = rnd ? ($urandom_range(3) != 0) : 1'b1;
            read_rdy  = rnd ? ($urandom_range(3) != 0) : 1'b1;
            res_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
            hold_a    = rnd ? ($urandom_range(3) == 0) : 1'b0;
            hold_b    = rnd ? ($urandom_range(3) == 0) : 1'b0;
            if (busy && read_address == 3'd0 && write_address == 3'd0 && !res_valid && pa_n < ha)
                hold_a = 1;
            if (busy && write_address == 3'd5 && wrb_n < wrb) write_rdy = 0;
            if (res_valid && out_n < outst) res_ready = 0;
            refresh();
            cyc();
            k++;
            if (s_pa) begin pa_n++; c_pa_last = s_cyc; end
            if (s_busy && s_wa == 3'd5) begin
                if (!s_wrdy) check("wrb_stall_no_we", s_we, 0);
                wrb_n++;
            end
            if (s_we && s_wa == 3'd4) c_w4 = s_cyc;
            if (s_rv) begin
                if (!got_rv) c_rv = s_cyc;
                got_rv = 1;
                check("res_data", s_rd, a | b);
                check("op_ready_in_out", s_opr, 0);
                if (!s_rr) begin
                    out_n++;
                    check("txn_hold_in_out", s_txn, exp_txn);
                end
            end
            if (s_rvh) fin = 1;
            if (exp_to && s_err && !s_busy) fin = 1;
        end
        check("txn_finished", fin, 1);
        if (!exp_to) begin
            exp_txn = exp_txn + 16'd1;
            check("txn_count", txn_count, exp_txn);
            check("err_clear", err, 0);
            check("wr4_count", n_wr4, 1);
            check("wr4_data", wd4, a);
            check("wr5_count", n_wr5, 1);
            check("wr5_data", wd5, b);
            check("rd_count", n_rd, 1);
            check("res_within_256", (c_rv - c_acc) <= 256, 1);
            if (!rnd) begin
                check("poll_a_cycles", pa_n, ha + 1);
                check("wr4_after_status", c_w4, c_pa_last + 1);
                check("wr_b_cycles", wrb_n, wrb + 1);
                check("out_stall_cycles", out_n, outst);
            end
            // accept cycle is cycle 0; res_valid first seen in cycle 7
            if (chk_lat) check("latency", c_rv - c_acc, 7);
        end else begin
            check("to_poll_y_cycles", n_py, TO);
            check("to_err", err, 1);
            check("to_op_ready", op_ready, 1);
            check("to_no_read", n_rd, 0);
            check("to_txn_count", txn_count, exp_txn);
            check("to_wr4_count", n_wr4, 1);
            check("to_wr5_count", n_wr5, 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k;
        logic [7:0] ra, rb;
        RST = 1; op_a = '0; op_b = '0; op_valid = 0;
        res_ready = 1; write_rdy = 1; read_rdy = 1;
        exp_txn = '0;
        refresh();
        repeat (3) cyc();
        RST = 0;
        check_reset_outputs("por");

        // Ideal path: status set, readies high, result immediately available
        y_lat = 0;
        run_txn(8'h0F, 8'hF0, 0, 0, 0, 0, 0, 1);
        // a-FIFO status held low for 5 polls
        y_lat = 3;
        run_txn(8'h3C, 8'h81, 5, 0, 0, 0, 0, 0);
        // write_rdy low for 3 cycles in WR_B
        run_txn(8'h12, 8'h40, 0, 3, 0, 0, 0, 0);
        // consumer stalls for 10 cycles in OUT
        run_txn(8'hA5, 8'h0A, 0, 0, 10, 0, 0, 0);
        // result never reported: timeout
        hold_y = 1;
        run_txn(8'h77, 8'h08, 0, 0, 0, 0, 1, 0);
        hold_y = 0;
        refresh();

        // Reset in WR_B (operands still accepted while err is set)
        n_wr5 = 0;
        op_a = 8'hAA; op_b = 8'h55; op_valid = 1;
        k = 0;
        do begin cyc(); k++; end while (!s_acc && k < 50);
        check("rst_test_accept", s_acc, 1);
        op_valid = 0;
        k = 0;
        while (!(busy && write_address == 3'd5) && k < 50) begin cyc(); k++; end
        check("rst_test_in_wr_b", write_address, 5);
        write_rdy = 0; RST = 1;
        cyc();
        RST = 0; write_rdy = 1;
        check_reset_outputs("rst_mid");
        check("rst_no_wr5", n_wr5, 0);
        exp_txn = '0;
        y_lat = 2;
        run_txn(8'h01, 8'h02, 0, 0, 0, 0, 0, 0);

        // Randomized transactions with random readies and status holds
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            y_lat = $urandom_range(12);
            run_txn(ra, rb, 0, 0, 0, 1, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
